// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn sequencer: FSM states, player and
// board-cell encodings, and the one-hot move helpers.
package ttt_pkg;

  localparam int NUM_CELLS  = 9;
  localparam int CELL_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_MOVE = 3'd1,
    ST_VALIDATE  = 3'd2,
    ST_REQUEST   = 3'd3,
    ST_RELEASE   = 3'd4
  } seq_state_t;

  typedef enum logic {
    PLAYER_P1 = 1'b0,
    PLAYER_P2 = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10
  } cell_t;

  // Vectors that are not strictly one-hot map to cell 0; callers screen them first.
  function automatic logic [CELL_IDX_W-1:0] onehot_to_index(input logic [NUM_CELLS-1:0] onehot);
    logic [CELL_IDX_W-1:0] idx;
    case (onehot)
      9'b000000001: idx = 4'd0;
      9'b000000010: idx = 4'd1;
      9'b000000100: idx = 4'd2;
      9'b000001000: idx = 4'd3;
      9'b000010000: idx = 4'd4;
      9'b000100000: idx = 4'd5;
      9'b001000000: idx = 4'd6;
      9'b010000000: idx = 4'd7;
      9'b100000000: idx = 4'd8;
      default:      idx = 4'd0;
    endcase
    return idx;
  endfunction

  function automatic logic single_cell(input logic [NUM_CELLS-1:0] vec);
    return (vec != 9'd0) && ((vec & (vec - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw active-low button and debounces it on the shared poll tick.
// Reports a debounced level and a one-cycle press strobe.
module button_debouncer
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button_n,
  output logic pressed,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             sample;

  assign sample = ~sync_b;

  // Two-flop synchroniser; a released button idles high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= button_n;
      sync_b <= sync_a;
    end
  end

  // Count consecutive tick samples that disagree with the debounced level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        if (sample == pressed) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt     <= '0;
          pressed <= sample;
          press   <= sample;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: debounces both player buttons, validates the requested cell,
// performs the board write handshake and enforces the per-turn timeout.
module turn_sequencer
  import ttt_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int TIMEOUT_TICKS  = 10000
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst,
  input  logic                  p1_select_n,
  input  logic                  p2_select_n,
  input  logic [NUM_CELLS-1:0]  p1_move,
  input  logic [NUM_CELLS-1:0]  p2_move,
  input  logic                  game_active,
  input  logic [NUM_CELLS-1:0]  occupied,
  output logic                  wr_req,
  output logic [CELL_IDX_W-1:0] wr_cell,
  output logic                  wr_player,
  input  logic                  wr_ack,
  output logic                  turn,
  output logic                  invalid_pulse,
  output logic                  timeout_pulse
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam int TO_W     = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic                 tick_q;
  logic [TO_W-1:0]      timeout_cnt;
  seq_state_t           state;
  logic [NUM_CELLS-1:0] move;
  logic                 mover;
  logic                 abort_pending;

  logic p1_pressed;
  logic p1_press;
  logic p2_pressed;
  logic p2_press;
  logic turn_press;
  logic mover_pressed;

  assign tick          = (tick_cnt == TICK_LAST);
  assign turn_press    = (turn == PLAYER_P2) ? p2_press : p1_press;
  assign mover_pressed = (mover == PLAYER_P2) ? p2_pressed : p1_pressed;

  // Free-running poll-tick divider.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Debounced strobes appear one cycle after the tick that produced them; the
  // timeout runs on the delayed tick so a press can land on the expiry cycle.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_p1_debounce (
    .clk      (MAX10_CLK1_50),
    .rst      (rst),
    .tick     (tick),
    .button_n (p1_select_n),
    .pressed  (p1_pressed),
    .press    (p1_press)
  );

  button_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_p2_debounce (
    .clk      (MAX10_CLK1_50),
    .rst      (rst),
    .tick     (tick),
    .button_n (p2_select_n),
    .pressed  (p2_pressed),
    .press    (p2_press)
  );

  // Turn FSM with registered handshake outputs and event strobes.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      state         <= ST_IDLE;
      wr_req        <= 1'b0;
      wr_cell       <= '0;
      wr_player     <= PLAYER_P1;
      turn          <= PLAYER_P1;
      invalid_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
      move          <= '0;
      mover         <= PLAYER_P1;
      abort_pending <= 1'b0;
    end else begin
      invalid_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (game_active) begin
            state       <= ST_WAIT_MOVE;
            turn        <= PLAYER_P1;
            timeout_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_MOVE: begin
          if (!game_active) begin
            state <= ST_IDLE;
          end else if (turn_press) begin
            move  <= (turn == PLAYER_P2) ? p2_move : p1_move;
            mover <= turn;
            state <= ST_VALIDATE;
          end else if (tick_q) begin
            if (timeout_cnt == TO_LAST) begin
              timeout_pulse <= 1'b1;
              turn          <= ~turn;
              timeout_cnt   <= '0;
            end else begin
              timeout_cnt <= timeout_cnt + TO_W'(1);
            end
          end
        end
        ST_VALIDATE: begin
          if (!game_active) begin
            state <= ST_IDLE;
          end else if (single_cell(move) && ((move & occupied) == 9'd0)) begin
            wr_cell       <= onehot_to_index(move);
            wr_player     <= turn;
            wr_req        <= 1'b1;
            abort_pending <= 1'b0;
            state         <= ST_REQUEST;
          end else begin
            invalid_pulse <= 1'b1;
            state         <= ST_RELEASE;
          end
        end
        ST_REQUEST: begin
          // The write always completes; a game stop seen meanwhile ends in IDLE.
          if (wr_ack) begin
            wr_req        <= 1'b0;
            turn          <= ~turn;
            abort_pending <= 1'b0;
            state         <= (abort_pending || !game_active) ? ST_IDLE : ST_RELEASE;
          end else if (!game_active) begin
            abort_pending <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!game_active) begin
            state <= ST_IDLE;
          end else if (!mover_pressed) begin
            timeout_cnt <= '0;
            state       <= ST_WAIT_MOVE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          wr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL expose parameters: CLK_HZ, default 50_000_000, clock frequency; TICK_HZ, default 1000, polling-tick rate; DEBOUNCE_TICKS, default 8, stable ticks per button edge; TIMEOUT_TICKS, default 10000, ticks per turn before forfeit.
REQ-002 MAX10_CLK1_50  in  1  system clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 p1_select_n / p2_select_n  in  1 each  raw player buttons, active-low, asynchronous.
REQ-005 p1_move / p2_move  in  9 each  requested cell, one-hot, bit i = cell i (row-major 0..8).
REQ-006 game_active  in  1  game FSM is accepting moves.
REQ-007 occupied  in  9  board occupancy mask, bit i = cell i non-empty.
REQ-008 wr_req  out  1  board write request.
REQ-009 wr_cell  out  4  cell index 0..8 for the write.
REQ-010 wr_player  out  1  owner of the write: 0 = P1, 1 = P2.
REQ-011 wr_ack  in  1  board datapath accepted the write.
REQ-012 turn  out  1  player whose move is awaited: 0 = P1, 1 = P2.
REQ-013 invalid_pulse / timeout_pulse  out  1 each  single-cycle event strobes.

Function
REQ-014 SHALL generate a one-cycle tick every CLK_HZ/TICK_HZ clocks, using a free-running counter that wraps to 0.
REQ-015 SHALL double-flop each button, sample it on ticks, and report it pressed or released only after DEBOUNCE_TICKS consecutive equal samples.
REQ-016 SHALL implement states IDLE, WAIT_MOVE, VALIDATE, REQUEST, RELEASE.
REQ-017 IDLE: when game_active=1, go to WAIT_MOVE, set turn=0, clear the timeout counter.
REQ-018 WAIT_MOVE: on the debounced press of the turn player only, latch that player's move vector and go to VALIDATE; presses by the other player are ignored with no strobe.
REQ-019 VALIDATE (1 cycle): a move is valid iff exactly one bit is set and that bit is clear in occupied.
REQ-019a VALIDATE, valid move: load wr_cell with the encoded index and wr_player with turn, then go to REQUEST.
REQ-019b VALIDATE, invalid move: pulse invalid_pulse, keep turn, and go to RELEASE.
REQ-020 Latency: the debounced press is registered in cycle N, VALIDATE is in cycle N+1, and wr_req=1 from cycle N+2.
REQ-021 REQUEST: hold wr_req=1 with wr_cell and wr_player stable until wr_ack=1 is sampled.
REQ-021a REQUEST, on wr_ack=1: drive wr_req=0 the next cycle, toggle turn, and go to RELEASE.
REQ-022 RELEASE: wait for the debounced release of the button that caused the move, then clear the timeout counter and go to WAIT_MOVE.
REQ-023 The timeout counter SHALL increment on each tick in WAIT_MOVE only.
REQ-023a On reaching TIMEOUT_TICKS, the block SHALL pulse timeout_pulse, toggle turn, and clear the counter.
REQ-024 If a debounced press and timeout expiry occur in the same cycle, the press wins and no timeout_pulse is issued.
REQ-025 game_active=0 in any state except REQUEST SHALL force IDLE the next cycle.
REQ-025a In REQUEST, the handshake SHALL complete first and then go to IDLE, even if wr_ack and game_active fall in the same cycle.
REQ-026 wr_req SHALL never assert outside REQUEST, and wr_cell SHALL never exceed 8.

Reset
REQ-027 With rst=0 at a clock edge, the next state SHALL be as follows:
- state = IDLE
- wr_req = 0, wr_cell = 0, wr_player = 0, turn = 0
- invalid_pulse = 0, timeout_pulse = 0
- tick, debounce and timeout counters = 0
- debounced buttons = released
REQ-028 Reset mid-handshake SHALL drop wr_req immediately with no ack required; rst has priority over every other input.

Structure
REQ-029 A shared package ttt_pkg SHALL hold:
- the state enum
- the player encoding (P1=0, P2=1)
- the cell-index width (4)
- the board-cell encoding (00 empty, 01 P1, 10 P2)
REQ-030 A sub-module button_debouncer (one tick input, DEBOUNCE_TICKS parameter) SHALL be instantiated once per player button.
REQ-031 The one-hot-to-index encoder SHALL be a function in ttt_pkg.

Verification
REQ-032 Bench SHALL use CLK_HZ/TICK_HZ=4, DEBOUNCE_TICKS=2 and TIMEOUT_TICKS=5.
REQ-033 Scenario: P1 presses with p1_move=9'b000010000 and occupied=0 -> wr_req with wr_cell=4, wr_player=0; ack after 3 cycles -> wr_req drops the next cycle and turn=1.
REQ-034 Scenario: P2 presses with p2_move=9'b000000011 (two bits set) -> one invalid_pulse, no wr_req, turn stays 1.
REQ-035 Scenario: occupied=9'b000000001 and P1 move=9'b000000001 -> invalid_pulse; P2 press while turn=0 -> no response.
REQ-036 Scenario: no press for 5 ticks -> timeout_pulse and turn toggles; press on the expiry tick -> no timeout_pulse.
REQ-037 Scenario: rst=0 asserted during REQUEST -> wr_req=0 the next cycle and state=IDLE.
REQ-037a Scenario: game_active falls during REQUEST -> wr_req held until wr_ack, then IDLE.
